// File: rtl/mdu_defs.sv
// Shared multiply/divide definitions: md_op encodings, default latencies and
// op-class predicates used by e_mdu and the D-stage hazard unit.
package mdu_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    function automatic logic is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface e_mdu_if;

    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_rs;
    logic [31:0] md_rt;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    modport master (
        output md_start, md_op, md_rs, md_rt,
        input  md_busy, md_hi, md_lo
    );

    modport slave (
        input  md_start, md_op, md_rs, md_rt,
        output md_busy, md_hi, md_lo
    );

endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO. Results are computed at issue and
// committed after a fixed busy window to model multi-cycle latency.
module e_mdu
    import mdu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      reset,
    e_mdu_if.slave    md
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    md_state_e   state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0] hi, hi_d, lo, lo_d;
    logic [31:0] pend_hi, pend_hi_d, pend_lo, pend_lo_d;
    logic        pend_wr, pend_wr_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] div_den, quo_s, rem_s, quo_u, rem_u;

    assign prod_s = $signed({{32{md.md_rs[31]}}, md.md_rs}) *
                    $signed({{32{md.md_rt[31]}}, md.md_rt});
    assign prod_u = {32'b0, md.md_rs} * {32'b0, md.md_rt};

    // Zero divisor is replaced so the dividers stay defined; that result is never committed.
    assign div_den = (md.md_rt == '0) ? 32'd1 : md.md_rt;

    always_comb begin
        if (md.md_rs == 32'h8000_0000 && md.md_rt == 32'hFFFF_FFFF) begin
            quo_s = 32'h8000_0000;
            rem_s = '0;
        end else begin
            quo_s = $signed(md.md_rs) / $signed(div_den);
            rem_s = $signed(md.md_rs) % $signed(div_den);
        end
        quo_u = md.md_rs / div_den;
        rem_u = md.md_rs % div_den;
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        hi_d      = hi;
        lo_d      = lo;
        pend_hi_d = pend_hi;
        pend_lo_d = pend_lo;
        pend_wr_d = pend_wr;
        case (state)
            ST_IDLE: begin
                if (md.md_start) begin
                    if (is_mult(md.md_op)) begin
                        {pend_hi_d, pend_lo_d} = (md.md_op == MD_MULT) ? prod_s : prod_u;
                        pend_wr_d = 1'b1;
                        cnt_d     = CW'(MULT_CYCLES);
                        state_d   = ST_BUSY;
                    end else if (is_div(md.md_op)) begin
                        pend_hi_d = (md.md_op == MD_DIV) ? rem_s : rem_u;
                        pend_lo_d = (md.md_op == MD_DIV) ? quo_s : quo_u;
                        pend_wr_d = (md.md_rt != '0);
                        cnt_d     = CW'(DIV_CYCLES);
                        state_d   = ST_BUSY;
                    end else if (md.md_op == MD_MTHI) begin
                        hi_d = md.md_rs;
                    end else if (md.md_op == MD_MTLO) begin
                        lo_d = md.md_rs;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_d = ST_IDLE;
                    if (pend_wr) begin
                        hi_d = pend_hi;
                        lo_d = pend_lo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            hi      <= hi_d;
            lo      <= lo_d;
            pend_hi <= pend_hi_d;
            pend_lo <= pend_lo_d;
            pend_wr <= pend_wr_d;
        end
    end

    assign md.md_busy = (state == ST_BUSY);
    assign md.md_hi   = hi;
    assign md.md_lo   = lo;

endmodule
